// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader sits on the master side; the byte source and the memory sit on the slave side.
interface program_loader_if;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        WrEn;
   logic [31:0] WrAddress;
   logic [31:0] WrData;

   modport master (
      input  ByteIn,
      input  ByteValid,
      output ByteReady,
      output WrEn,
      output WrAddress,
      output WrData
   );

   modport slave (
      output ByteIn,
      output ByteValid,
      input  ByteReady,
      input  WrEn,
      input  WrAddress,
      input  WrData
   );
endinterface

// File: rtl/program_loader.sv
// Length-prefixed byte-stream loader that writes big-endian words to instruction memory and holds the CPU meanwhile.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module program_loader #(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   program_loader_if.master Bus,
   output logic             CpuHold,
   output logic             Done,
   output logic             Error,
   output logic [15:0]      WordCount
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   state_t      state_r;
   logic [7:0]  len_hi_r;
   logic [15:0] len_r;
   logic [1:0]  byte_cnt_r;
   logic [23:0] asm_r;

   logic        xfer_s;
   logic [15:0] len_s;
   logic [31:0] word_s;
   logic [31:0] addr_s;
   logic        last_word_s;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum_r;

   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
`endif

   assign xfer_s      = Bus.ByteValid & Bus.ByteReady;
   assign len_s       = {len_hi_r, Bus.ByteIn};
   assign word_s      = {asm_r, Bus.ByteIn};
   assign addr_s      = BASE_ADDR + {14'd0, WordCount, 2'b00};
   assign last_word_s = ((WordCount + 16'd1) == len_r);

   // Loader FSM: stream parsing, word assembly and all registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r       <= S_IDLE;
         len_hi_r      <= 8'd0;
         len_r         <= 16'd0;
         byte_cnt_r    <= 2'd0;
         asm_r         <= 24'd0;
         Bus.ByteReady <= 1'b0;
         Bus.WrEn      <= 1'b0;
         Bus.WrAddress <= 32'd0;
         Bus.WrData    <= 32'd0;
         CpuHold       <= 1'b0;
         Done          <= 1'b0;
         Error         <= 1'b0;
         WordCount     <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_r        <= 8'd0;
`endif
      end else begin
         Bus.WrEn <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
               if (Start) begin
                  state_r       <= S_LEN_HI;
                  Done          <= 1'b0;
                  Error         <= 1'b0;
                  WordCount     <= 16'd0;
                  byte_cnt_r    <= 2'd0;
                  asm_r         <= 24'd0;
                  CpuHold       <= 1'b1;
                  Bus.ByteReady <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  csum_r        <= 8'd0;
`endif
               end else begin
                  state_r <= state_r;
               end
            end

            S_LEN_HI: begin
               if (xfer_s) begin
                  len_hi_r <= Bus.ByteIn;
                  state_r  <= S_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                  csum_r   <= csum_update(8'd0, Bus.ByteIn);
`endif
               end else begin
                  state_r <= state_r;
               end
            end

            S_LEN_LO: begin
               if (xfer_s) begin
                  len_r <= len_s;
`ifdef LOADER_CHECKSUM_EN
                  csum_r <= csum_update(csum_r, Bus.ByteIn);
`endif
                  if (len_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state_r <= S_CHECK;
`else
                     state_r       <= S_DONE;
                     Done          <= 1'b1;
                     CpuHold       <= 1'b0;
                     Bus.ByteReady <= 1'b0;
`endif
                  end else if (len_s > MAX_N) begin
                     // CpuHold stays high so the core never runs a partial image
                     state_r       <= S_ERROR;
                     Error         <= 1'b1;
                     Bus.ByteReady <= 1'b0;
                  end else begin
                     state_r <= S_DATA;
                  end
               end else begin
                  state_r <= state_r;
               end
            end

            S_DATA: begin
               if (xfer_s) begin
                  asm_r      <= {asm_r[15:0], Bus.ByteIn};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum_r     <= csum_update(csum_r, Bus.ByteIn);
`endif
                  if (byte_cnt_r == 2'd3) begin
                     Bus.WrEn      <= 1'b1;
                     Bus.WrData    <= word_s;
                     Bus.WrAddress <= addr_s;
                     WordCount     <= WordCount + 16'd1;
                     if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                        state_r <= S_CHECK;
`else
                        state_r       <= S_DONE;
                        Done          <= 1'b1;
                        CpuHold       <= 1'b0;
                        Bus.ByteReady <= 1'b0;
`endif
                     end else begin
                        state_r <= state_r;
                     end
                  end else begin
                     state_r <= state_r;
                  end
               end else begin
                  state_r <= state_r;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (xfer_s) begin
                  Bus.ByteReady <= 1'b0;
                  if (Bus.ByteIn == csum_r) begin
                     state_r <= S_DONE;
                     Done    <= 1'b1;
                     CpuHold <= 1'b0;
                  end else begin
                     // Words already written stay in memory; the CPU stays frozen
                     state_r <= S_ERROR;
                     Error   <= 1'b1;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
`endif

            default: begin
               state_r       <= S_IDLE;
               Bus.ByteReady <= 1'b0;
               CpuHold       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed loads plus randomized streams against a word-level reference model.
module tb_program_loader;
   localparam int          MAX_WORDS = 256;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic        CpuHold;
   logic        Done;
   logic        Error;
   logic [15:0] WordCount;

   program_loader_if bus();

   program_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Bus(bus),
      .CpuHold(CpuHold), .Done(Done), .Error(Error), .WordCount(WordCount)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        done;
      logic        hold;
   } wr_t;
   wr_t wr_q[$];

   // Write monitor: memory-side view of every WrEn pulse
   always @(negedge Clk) begin
      if (bus.WrEn === 1'b1) wr_q.push_back('{bus.WrAddress, bus.WrData, Done, CpuHold});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(bus.ByteReady), 32'd0);
      chk({tag, "_wren"},  32'(bus.WrEn),      32'd0);
      chk({tag, "_addr"},  bus.WrAddress,      32'd0);
      chk({tag, "_data"},  bus.WrData,         32'd0);
      chk({tag, "_hold"},  32'(CpuHold),       32'd0);
      chk({tag, "_done"},  32'(Done),          32'd0);
      chk({tag, "_error"}, 32'(Error),         32'd0);
      chk({tag, "_count"}, 32'(WordCount),     32'd0);
   endtask

   task automatic do_start();
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      chk("start_hold",  32'(CpuHold),       32'd1);
      chk("start_ready", 32'(bus.ByteReady), 32'd1);
      chk("start_done",  32'(Done),          32'd0);
      chk("start_count", 32'(WordCount),     32'd0);
   endtask

   // gap: insert one idle cycle before the byte; noise: wiggle Start (never on the last byte)
   task automatic send_byte(input logic [7:0] b, input bit gap, input bit noise, input bit last);
      if (gap) begin
         bus.ByteValid = 1'b0;
         bus.ByteIn    = 8'($urandom);
         Start         = (noise && !last) ? 1'($urandom) : 1'b0;
         @(negedge Clk);
      end
      chk("ready_during_load", 32'(bus.ByteReady), 32'd1);
      bus.ByteValid = 1'b1;
      bus.ByteIn    = b;
      Start         = (noise && !last) ? 1'($urandom) : 1'b0;
      @(negedge Clk);
      bus.ByteValid = 1'b0;
      Start         = 1'b0;
   endtask

   // Reference: N words from 4N bytes, big-endian, consecutive addresses; XOR checksum over everything
   task automatic do_load(input logic [7:0] data[$], input int n, input int gap_mode,
                          input bit noise, input bit bad);
      logic [7:0] stream[$];
      logic [7:0] cs;
      bit         over;
      bit         bad_eff;
      int         exp_w;
      over    = (n > MAX_WORDS);
      bad_eff = bad && CSUM && !over;
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      if (!over) foreach (data[i]) stream.push_back(data[i]);
      cs = 8'd0;
      foreach (stream[i]) cs = cs ^ stream[i];
      if (CSUM && !over) stream.push_back(bad_eff ? (cs ^ 8'h01) : cs);

      wr_q.delete();
      do_start();
      foreach (stream[i]) begin
         send_byte(stream[i], (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1),
                   noise, i == stream.size() - 1);
      end
      #2;
      exp_w = over ? 0 : n;
      chk("wr_count", 32'(wr_q.size()), 32'(exp_w));
      for (int i = 0; i < exp_w; i++) begin
         if (i < wr_q.size()) begin
            chk("wr_addr", wr_q[i].addr, BASE_ADDR + 32'(4 * i));
            chk("wr_data", wr_q[i].data, {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]});
            chk("wr_done_flag", 32'(wr_q[i].done), 32'((i == exp_w - 1) && !CSUM));
            chk("wr_hold_flag", 32'(wr_q[i].hold), 32'(!((i == exp_w - 1) && !CSUM)));
         end
      end
      chk("end_done",  32'(Done),          32'(!over && !bad_eff));
      chk("end_error", 32'(Error),         32'(over || bad_eff));
      chk("end_hold",  32'(CpuHold),       32'(over || bad_eff));
      chk("end_ready", 32'(bus.ByteReady), 32'd0);
      chk("end_count", 32'(WordCount),     32'(exp_w));
   endtask

   initial begin
      logic [7:0]  prog[$];
      logic [7:0]  d[$];
      logic [31:0] exp_words[5];
      int          n;

      Reset         = 1'b1;
      Start         = 1'b0;
      bus.ByteValid = 1'b0;
      bus.ByteIn    = 8'd0;
      repeat (2) @(negedge Clk);
      check_reset_outputs("reset");
      Reset = 1'b0;
      @(negedge Clk);

      // Directed program at full rate, then with ByteValid toggling
      prog = {8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h01, 8'h09,
              8'h50, 8'h20, 8'hAC, 8'h0A, 8'h00, 8'h00, 8'h8C, 8'h0B, 8'h00, 8'h00};
      exp_words = '{32'h20080005, 32'h2009000A, 32'h01095020, 32'hAC0A0000, 32'h8C0B0000};
      do_load(prog, 5, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) if (i < wr_q.size()) chk("prog_word", wr_q[i].data, exp_words[i]);
      do_load(prog, 5, 1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) if (i < wr_q.size()) chk("prog_word_toggle", wr_q[i].data, exp_words[i]);

      // Oversized length, then empty program from ERROR
      d.delete();
      do_load(d, 257, 0, 1'b0, 1'b0);
      do_load(d, 0, 0, 1'b0, 1'b0);

      // Reset after six data bytes: only word 0 reaches memory
      wr_q.delete();
      do_start();
      send_byte(8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'h05, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0, 1'b0, 1'b0);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      #2;
      chk("rst_mid_wr_count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) chk("rst_mid_word0", wr_q[0].data, 32'h20080005);
      check_reset_outputs("rst_mid");
      @(negedge Clk);

`ifdef LOADER_CHECKSUM_EN
      d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load(d, 1, 0, 1'b0, 1'b0);
      do_load(d, 1, 0, 1'b0, 1'b1);
`endif

      // Largest accepted program
      d.delete();
      for (int i = 0; i < 4 * MAX_WORDS; i++) d.push_back(8'($urandom));
      do_load(d, MAX_WORDS, 2, 1'b0, 1'b0);

      // Randomized loads with stalls and stray Start pulses
      for (int it = 0; it < 24; it++) begin
         n = $urandom_range(1, 12);
         if (it % 7 == 3) n = 0;
         if (it % 9 == 5) n = 257 + $urandom_range(0, 4000);
         d.delete();
         if (n <= MAX_WORDS) for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
         do_load(d, n, 2, 1'b1, 1'($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
